// File: rtl/fol_pkg.sv
// Shared constants and types for the first-order low-pass inverse pipeline.
// Q15 coefficient arithmetic helpers live here so every stage agrees on scaling.
package fol_pkg;

    localparam int unsigned Q15_ONE         = 32768;
    localparam int unsigned Q15_SHIFT       = 15;
    localparam int unsigned GAIN_FRAC       = 8;
    localparam int unsigned FOL_INV_LATENCY = 4;

    typedef logic signed [15:0] sample_t;
    typedef logic        [15:0] coef_t;
    typedef logic        [16:0] one_minus_t;

    // 1-a as 17-bit unsigned so a=0 yields exactly 1.0 (32768)
    function automatic one_minus_t one_minus_a(input coef_t a);
        return one_minus_t'(Q15_ONE) - {1'b0, a};
    endfunction

endpackage

// File: rtl/fol_sat_reduce.sv
// Narrows the wide scaled result to DW bits and flags out-of-range values.
// FOL_INVERSE_SAT_EN selects clamping; otherwise the low DW bits are kept (wrap).
module fol_sat_reduce #(
    parameter int unsigned DW = 16,
    parameter int unsigned GW = 16
) (
    input  logic signed [DW+GW+1:0] i_wide,
    output logic signed [DW-1:0]    o_narrow,
    output logic                    o_ovf
);

    // Value fits in DW bits only when every bit from the DW sign position upward agrees
    logic [GW+2:0] upper;
    assign upper = i_wide[DW+GW+1:DW-1];
    assign o_ovf = !((upper == '0) || (upper == '1));

`ifdef FOL_INVERSE_SAT_EN
    always_comb begin
        o_narrow = i_wide[DW-1:0];
        if (o_ovf) begin
            o_narrow = i_wide[DW+GW+1] ? {1'b1, {(DW-1){1'b0}}}
                                       : {1'b0, {(DW-1){1'b1}}};
        end
    end
`else
    assign o_narrow = i_wide[DW-1:0];
`endif

endmodule

// File: rtl/fol_inverse16.sv
// Four-stage inverse of y(n)=a*x(n)+(1-a)*y(n-1): x(n)=k*(y(n)-(1-a)*y(n-1)).
// Optional FOL_INVERSE_SAT_EN adds output clamping and the sticky o_sat port.
module fol_inverse16
    import fol_pkg::*;
#(
    parameter int unsigned DW = 16,
    parameter int unsigned GW = 16
) (
    input  logic                 i_clkp,
    input  logic                 i_rstn,
    input  logic [15:0]          i_a0,
    input  logic [GW-1:0]        i_gain,
    input  logic                 i_clear,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic signed [DW-1:0] i_sample,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic signed [DW-1:0] o_sample
`ifdef FOL_INVERSE_SAT_EN
    ,
    output logic                 o_sat
`endif
);

    logic                    stall, adv, accept;
    logic signed [DW-1:0]    y_hist;

    logic                    s0_v, s1_v, s2_v;
    logic signed [DW-1:0]    s0_y, s0_yprev, s1_y;
    coef_t                   s0_a;
    logic [GW-1:0]           s0_k, s1_k, s2_k;
    logic signed [DW+17:0]   s1_prod, s2_diff;
    logic signed [DW+1:0]    s2_d;
    logic signed [DW+GW+2:0] s3_prod;
    logic signed [DW+GW+1:0] s3_wide;
    logic signed [DW-1:0]    s3_narrow;
    logic                    s3_ovf;

    // Single global stall: every stage freezes while the output is blocked
    assign stall   = o_valid && !i_ready;
    assign adv     = !stall;
    assign o_ready = adv;
    assign accept  = i_valid && adv;

    // History: clear wins over the accepted sample, but S0 already captured the old value
    always_ff @(posedge i_clkp or negedge i_rstn) begin
        if (!i_rstn) begin
            y_hist <= '0;
        end else if (i_clear) begin
            y_hist <= '0;
        end else if (accept) begin
            y_hist <= i_sample;
        end
    end

    always_ff @(posedge i_clkp or negedge i_rstn) begin
        if (!i_rstn) begin
            s0_v     <= 1'b0;
            s0_y     <= '0;
            s0_yprev <= '0;
            s0_a     <= '0;
            s0_k     <= '0;
        end else if (adv) begin
            s0_v <= accept;
            if (accept) begin
                s0_y     <= i_sample;
                s0_yprev <= y_hist;
                s0_a     <= i_a0;
                s0_k     <= i_gain;
            end
        end
    end

    always_ff @(posedge i_clkp or negedge i_rstn) begin
        if (!i_rstn) begin
            s1_v    <= 1'b0;
            s1_y    <= '0;
            s1_k    <= '0;
            s1_prod <= '0;
        end else if (adv) begin
            s1_v    <= s0_v;
            s1_y    <= s0_y;
            s1_k    <= s0_k;
            s1_prod <= (DW+18)'($signed({1'b0, one_minus_a(s0_a)})) * (DW+18)'(s0_yprev);
        end
    end

    assign s2_diff = ((DW+18)'(s1_y) <<< Q15_SHIFT) - s1_prod;

    always_ff @(posedge i_clkp or negedge i_rstn) begin
        if (!i_rstn) begin
            s2_v <= 1'b0;
            s2_k <= '0;
            s2_d <= '0;
        end else if (adv) begin
            s2_v <= s1_v;
            s2_k <= s1_k;
            s2_d <= (DW+2)'(s2_diff >>> Q15_SHIFT);
        end
    end

    assign s3_prod = (DW+GW+3)'(s2_d) * (DW+GW+3)'($signed({1'b0, s2_k}));
    assign s3_wide = (DW+GW+2)'(s3_prod >>> GAIN_FRAC);

    fol_sat_reduce #(
        .DW (DW),
        .GW (GW)
    ) u_sat_reduce (
        .i_wide   (s3_wide),
        .o_narrow (s3_narrow),
        .o_ovf    (s3_ovf)
    );

    always_ff @(posedge i_clkp or negedge i_rstn) begin
        if (!i_rstn) begin
            o_valid  <= 1'b0;
            o_sample <= '0;
        end else if (adv) begin
            o_valid <= s2_v;
            if (s2_v) begin
                o_sample <= s3_narrow;
            end
        end
    end

`ifdef FOL_INVERSE_SAT_EN
    always_ff @(posedge i_clkp or negedge i_rstn) begin
        if (!i_rstn) begin
            o_sat <= 1'b0;
        end else if (adv && s2_v && s3_ovf) begin
            o_sat <= 1'b1;
        end
    end
`else
    logic ovf_unused;
    assign ovf_unused = s3_ovf;
`endif

endmodule

// File: tb/tb_fol_inverse16.sv
// Self-checking bench for fol_inverse16: directed vectors plus randomized traffic
// checked against an arithmetic reference model; honours FOL_INVERSE_SAT_EN.
module tb_fol_inverse16;
    import fol_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned GW = 16;

    logic                 i_clkp = 1'b0;
    logic                 i_rstn;
    logic [15:0]          i_a0;
    logic [GW-1:0]        i_gain;
    logic                 i_clear;
    logic                 i_valid;
    logic                 o_ready;
    logic signed [DW-1:0] i_sample;
    logic                 o_valid;
    logic                 i_ready;
    logic signed [DW-1:0] o_sample;
`ifdef FOL_INVERSE_SAT_EN
    logic                 o_sat;
`endif

    fol_inverse16 #(
        .DW (DW),
        .GW (GW)
    ) dut (
        .i_clkp   (i_clkp),
        .i_rstn   (i_rstn),
        .i_a0     (i_a0),
        .i_gain   (i_gain),
        .i_clear  (i_clear),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_sample (i_sample),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_sample (o_sample)
`ifdef FOL_INVERSE_SAT_EN
        ,
        .o_sat    (o_sat)
`endif
    );

    always #5 i_clkp = ~i_clkp;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Floor division, as the spec's arithmetic shifts truncate toward minus infinity
    function automatic longint floor_div(input longint n, input longint m);
        longint q;
        q = n / m;
        if ((n % m != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    typedef struct {
        longint val;
        bit     ovf;
    } exp_t;

    function automatic exp_t model(input longint y, input longint prev, input longint a, input longint k);
        exp_t   e;
        longint d, s, r;
        d = floor_div(y * 32768 - (32768 - a) * prev, 32768);
        s = floor_div(d * k, 256);
        e.ovf = (s > 32767) || (s < -32768);
`ifdef FOL_INVERSE_SAT_EN
        r = e.ovf ? ((s > 0) ? 32767 : -32768) : s;
`else
        r = s % 65536;
        if (r < 0) r += 65536;
        if (r >= 32768) r -= 65536;
`endif
        e.val = r;
        return e;
    endfunction

    exp_t   exp_q[$];
    longint obs[$];
    longint hist;
    bit     sat_exp;
    int     ncyc;
    bit     lat_arm;
    int     lat_acc, lat_val;

    // Reference: track history and queue expected results at each accept
    always @(negedge i_clkp) begin
        if (!i_rstn) begin
            exp_q.delete();
            hist    = 0;
            sat_exp = 0;
        end else begin
            ncyc++;
            if (o_valid && i_ready) begin
                check("xfer_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("o_sample", o_sample, e.val);
                    sat_exp |= e.ovf;
`ifdef FOL_INVERSE_SAT_EN
                    check("o_sat", o_sat, sat_exp);
`endif
                    obs.push_back(longint'(o_sample));
                end
            end else if (o_valid && exp_q.size() > 0) begin
                check("hold_sample", o_sample, exp_q[0].val);
            end
            if (lat_arm && o_valid && lat_val < 0) lat_val = ncyc;
            if (i_valid && o_ready) begin
                exp_q.push_back(model(longint'(i_sample), hist, longint'(i_a0), longint'(i_gain)));
                if (lat_arm && lat_acc < 0) lat_acc = ncyc;
                hist = i_clear ? 0 : longint'(i_sample);
            end else if (i_clear) begin
                hist = 0;
            end
        end
    end

    task automatic tick();
        @(posedge i_clkp);
        #1;
    endtask

    task automatic send(input int y);
        i_valid  = 1'b1;
        i_sample = DW'(y);
        for (int t = 0; t < 50; t++) begin
            @(negedge i_clkp);
            if (o_ready) break;
        end
        tick();
        i_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
    endtask

    task automatic do_reset();
        i_rstn = 1'b0;
        tick();
        tick();
        i_rstn = 1'b1;
        tick();
    endtask

    task automatic drain();
        int t;
        i_ready = 1'b1;
        t = 0;
        while ((exp_q.size() != 0 || o_valid) && t < 200) begin
            tick();
            t++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic set_coef(input int a, input int k);
        i_a0   = 16'(a);
        i_gain = GW'(k);
    endtask

    initial begin
        i_rstn = 1'b0; i_a0 = '0; i_gain = '0; i_clear = 1'b0;
        i_valid = 1'b0; i_sample = '0; i_ready = 1'b1;
        lat_arm = 0; lat_acc = -1; lat_val = -1;
        tick(); tick();
        check("rst_o_valid", o_valid, 0);
        check("rst_o_sample", o_sample, 0);
`ifdef FOL_INVERSE_SAT_EN
        check("rst_o_sat", o_sat, 0);
`endif
        i_rstn = 1'b1;
        tick();
        check("rst_o_ready", o_ready, 1);

        // Inverse step with latency measurement
        set_coef(16384, 'h200);
        obs.delete();
        lat_arm = 1;
        send(500); send(750); send(875); send(937);
        drain();
        lat_arm = 0;
        check("latency", lat_val - lat_acc, FOL_INV_LATENCY);
        check("step_n", obs.size(), 4);
        if (obs.size() == 4) begin
            check("step0", obs[0], 1000);
            check("step1", obs[1], 1000);
            check("step2", obs[2], 1000);
            check("step3", obs[3], 998);
        end

        // Differentiator
        pulse_clear();
        set_coef(0, 'h100);
        obs.delete();
        send(0); send(100); send(300); send(300);
        drain();
        check("diff_n", obs.size(), 4);
        if (obs.size() == 4) begin
            check("diff0", obs[0], 0);
            check("diff1", obs[1], 100);
            check("diff2", obs[2], 200);
            check("diff3", obs[3], 0);
        end

        // Backpressure: 3-cycle stall mid-stream
        set_coef(16384, 'h200);
        obs.delete();
        fork
            begin
                for (int i = 0; i < 8; i++) send(int'($urandom_range(0, 4000)) - 2000);
            end
            begin
                repeat (6) tick();
                i_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge i_clkp);
                    check("stall_o_ready", o_ready, 0);
                    check("stall_o_valid", o_valid, 1);
                    tick();
                end
                i_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", obs.size(), 8);

        // Saturation / wrap boundary
        pulse_clear();
        set_coef(32768, 'h200);
        obs.delete();
        send(32767);
        drain();
        check("sat_n", obs.size(), 1);
        if (obs.size() == 1) begin
`ifdef FOL_INVERSE_SAT_EN
            check("sat_val", obs[0], 32767);
            check("sat_flag", o_sat, 1);
`else
            check("wrap_val", obs[0], -2);
`endif
        end

        // Clear then re-send
        set_coef(16384, 'h200);
        send(1000);
        drain();
        pulse_clear();
        obs.delete();
        send(1000);
        drain();
        if (obs.size() == 1) check("clear_val", obs[0], 2000);
        else check("clear_n", obs.size(), 1);

        // Reset then re-send
        send(1000);
        drain();
        do_reset();
        obs.delete();
        send(1000);
        drain();
        if (obs.size() == 1) check("reset_val", obs[0], 2000);
        else check("reset_n", obs.size(), 1);

        // Bubbles do not disturb history
        pulse_clear();
        obs.delete();
        send(500);
        repeat (5) tick();
        send(750);
        drain();
        if (obs.size() == 2) check("bubble_val", obs[1], 1000);
        else check("bubble_n", obs.size(), 2);

        // Reset with samples in flight
        send(1200); send(-300); send(4000);
        do_reset();
        check("midrst_o_valid", o_valid, 0);
        obs.delete();
        send(1000);
        drain();
        if (obs.size() == 1) check("midrst_val", obs[0], 2000);
        else check("midrst_n", obs.size(), 1);

        // Randomized traffic, including clear coinciding with accepts
        for (int i = 0; i < 400; i++) begin
            i_valid  = ($urandom_range(0, 9) < 7);
            i_ready  = ($urandom_range(0, 3) != 0);
            i_clear  = ($urandom_range(0, 19) == 0);
            i_sample = DW'($urandom);
            i_a0     = 16'($urandom_range(0, 32768));
            i_gain   = ($urandom_range(0, 1) != 0) ? GW'($urandom) : GW'($urandom_range(0, 'h200));
            tick();
        end
        i_valid = 1'b0;
        i_clear = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/fol_inverse16.md
FOL_INVERSE16 -- requirements
Module: fol_inverse16

Interface
REQ-001 Parameter: DW, default 16, sample width in bits (signed).
REQ-002 Parameter: GW, default 16, gain width in bits (unsigned Q8.8).
REQ-003 i_clkp  input  1  clock, all logic on rising edge.
REQ-004 i_rstn  input  1  reset, asynchronous, active-low.
REQ-005 i_a0  input  16  unsigned Q15 low-pass factor a, legal range 0..32768.
REQ-006 i_gain  input  GW  unsigned Q8.8 gain k, nominally 1/a, supplied precomputed.
REQ-007 i_clear  input  1  synchronous clear of history y(n-1).
REQ-008 i_valid / o_ready  input / output  1  upstream handshake; a sample is accepted when both are high.
REQ-009 i_sample  input  DW  signed y(n), the output of a first-order low-pass stage.
REQ-010 o_valid / i_ready  output / input  1  downstream handshake; a result is transferred when both are high.
REQ-011 o_sample  output  DW  signed reconstructed x(n).
REQ-012 o_sat  output  1  sticky saturation flag; exists only under the macro.

Function
REQ-013 Compute x(n) = k*(y(n) - (1-a)*y(n-1)), which inverts y(n)=a*x(n)+(1-a)*y(n-1).
REQ-014 Compute (1-a) as 17-bit unsigned 32768-a, so a=0 gives exactly 1.0.
REQ-015 Stage S0 registers y(n), a, k and y(n-1) on accept, then loads y(n-1) with y(n).
REQ-016 Stage S1 forms the signed product (1-a)*y(n-1) at 34 bits, full precision.
REQ-017 Stage S2 forms d = ((y(n)<<15) - product) >>> 15, arithmetic shift, truncating toward minus infinity, held at DW+2 bits.
REQ-018 Stage S3 forms (d*k) >>> 8, then reduces the result to DW bits per REQ-029/030.
REQ-019 Latency from accept to o_valid is 4 cycles with no stall; throughput is 1 sample per cycle.
REQ-020 Each stage carries a valid bit; the whole pipeline stalls when o_valid=1 and i_ready=0.
REQ-021 o_ready = !(o_valid && !i_ready); backpressure propagates combinationally.
REQ-022 o_sample and o_valid hold stable while stalled; no sample is dropped or duplicated.
REQ-023 y(n-1) updates only on accepted samples; bubbles do not disturb history.
REQ-024 i_clear zeroes y(n-1) in the cycle it is high; if i_clear and an accept occur together, the accepted sample uses the old history, and the history becomes 0 rather than y(n).
REQ-025 i_clear does not flush samples already in flight.
REQ-026 a and k are sampled per accepted sample; changes apply from the next accept onward.

Reset
REQ-027 On i_rstn low: all stage valids = 0, o_valid = 0, o_sample = 0, y(n-1) = 0, o_sat = 0, and o_ready = 1 after release.
REQ-028 Reset mid-stream discards all in-flight samples; the first sample after reset uses y(n-1) = 0.

Configuration
REQ-029 With FOL_INVERSE_SAT_EN defined: S3 results outside the signed DW range clamp to +/-(2^(DW-1)) limits and set o_sat, which stays set until reset.
REQ-030 Without FOL_INVERSE_SAT_EN: S3 keeps the low DW bits (two's-complement wrap), and o_sat is absent from the port list.

Structure
REQ-031 Shared package fol_pkg holds Q15_ONE=32768, Q15_SHIFT=15, GAIN_FRAC=8, FOL_INV_LATENCY=4, and the sample/coef typedefs.
REQ-032 One sub-module, fol_sat_reduce, performs the DW+GW+2 to DW clamp/wrap and emits the per-sample overflow bit.
REQ-033 Multipliers are inferred in S1 and S3; no other hierarchy.

Verification
REQ-034 Inverse step: a=16384, k=0x0200; feed y=500,750,875,937 continuously with i_ready=1 -> o_sample=1000,1000,1000,998, the first valid 4 cycles after the first accept.
REQ-035 Differentiator: a=0, k=0x0100; y=0,100,300,300 -> x=0,100,200,0.
REQ-036 Backpressure: stream 8 samples, i_ready=0 for 3 cycles mid-stream -> o_sample holds, o_ready=0 during the stall, all 8 results appear in order with no loss.
REQ-037 Saturation: a=32768, k=0x0200, y=32767 -> with the macro, o_sample=32767 and o_sat=1; without the macro, o_sample=-2.
REQ-038 Clear/reset: after y=1000 accepted, pulse i_clear (or reset), then send y=1000 with a=16384, k=0x0200 -> o_sample=2000.
REQ-039 Bubbles: a=16384, k=0x0200, y=500 and y=750 separated by 5 idle cycles with i_valid=0 -> second result is 1000, so history is unaffected by the bubbles.
